// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and elaboration helpers for the round-robin grant scheduler.
// Holds the FSM state encoding and the clamped-width helpers used by the top.
package rr_grant_scheduler_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_e;

    // At least two requesters are needed for the rotation arithmetic to make sense.
    function automatic int clamp_req(input int n);
        return (n < 2) ? 2 : n;
    endfunction

    function automatic int hcnt_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_grant_scheduler_ffs.sv
// Find-first-set: reports the first set bit of vec as index and one-hot.
// SIDE!=0 searches from the LSB, SIDE==0 from the MSB.
module ffs_m #(
    parameter int   W     = 8,
    parameter int   SIDE  = 1,
    parameter int   USE_X = 0,
    localparam int  IW    = (W < 2) ? 1 : $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic          found,
    output logic [IW-1:0] idx,
    output logic [W-1:0]  onehot
);

    logic [IW-1:0] idx_s;
    logic          hit_s;
    int            j_s;

    // Priority scan; a bit only counts if nothing earlier in scan order was set.
    always_comb begin
        found  = 1'b0;
        idx_s  = '0;
        onehot = '0;
        hit_s  = 1'b0;
        j_s    = 0;
        for (int i = 0; i < W; i++) begin
            j_s    = (SIDE != 0) ? i : (W - 1 - i);
            hit_s  = vec[j_s] & ~found;
            idx_s  = hit_s ? IW'(j_s) : idx_s;
            onehot[j_s] = hit_s;
            found  = found | vec[j_s];
        end
        idx = ((USE_X != 0) && !found) ? {IW{1'bx}} : idx_s;
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: registered one-hot grant held until release,
// request drop or hold timeout, with back-to-back handover to the next requester.
module rr_grant_scheduler
    import rr_grant_scheduler_pkg::*;
#(
    parameter int  NUM_REQ  = 8,
    parameter int  MAX_HOLD = 0,
    localparam int N        = clamp_req(NUM_REQ),
    localparam int ID_W     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            release_grant,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id
);

    localparam int HCNT_W = hcnt_width(MAX_HOLD);

    sched_state_e    state_r;
    logic [ID_W-1:0] ptr_r;
    logic [HCNT_W-1:0] hcnt_r;

    logic [ID_W-1:0] next_ptr_s;
    logic [ID_W-1:0] sel_ptr_s;
    logic [N-1:0]    cand_s;
    logic [N-1:0]    mask_s;
    logic [N-1:0]    masked_s;
    logic            timeout_s;
    logic            end_s;

    logic            m_found_s;
    logic [ID_W-1:0] m_idx_s;
    logic [N-1:0]    m_onehot_s;
    logic            r_found_s;
    logic [ID_W-1:0] r_idx_s;
    logic [N-1:0]    r_onehot_s;

    logic            win_found_s;
    logic [ID_W-1:0] win_idx_s;
    logic [N-1:0]    win_onehot_s;

    // Candidate vector and search pointer; in BUSY they already assume the grant ends,
    // so the departing owner is excluded and the pointer has moved past it.
    always_comb begin
        next_ptr_s = (grant_id == ID_W'(N - 1)) ? {ID_W{1'b0}} : (grant_id + ID_W'(1));
        if (MAX_HOLD != 0) begin
            timeout_s = (hcnt_r == HCNT_W'(MAX_HOLD - 1));
        end else begin
            timeout_s = 1'b0;
        end
        end_s = release_grant | ~req[grant_id] | timeout_s;
        if (state_r == BUSY) begin
            cand_s    = req & ~grant;
            sel_ptr_s = next_ptr_s;
        end else begin
            cand_s    = req;
            sel_ptr_s = ptr_r;
        end
        mask_s = '0;
        for (int i = 0; i < N; i++) begin
            mask_s[i] = (i >= int'(sel_ptr_s));
        end
        masked_s     = cand_s & mask_s;
        win_found_s  = m_found_s | r_found_s;
        win_idx_s    = m_found_s ? m_idx_s : r_idx_s;
        win_onehot_s = m_found_s ? m_onehot_s : r_onehot_s;
    end

    ffs_m #(.W(N), .SIDE(1), .USE_X(0)) u_ffs_masked (
        .vec    (masked_s),
        .found  (m_found_s),
        .idx    (m_idx_s),
        .onehot (m_onehot_s)
    );

    ffs_m #(.W(N), .SIDE(1), .USE_X(0)) u_ffs_raw (
        .vec    (cand_s),
        .found  (r_found_s),
        .idx    (r_idx_s),
        .onehot (r_onehot_s)
    );

    // Scheduler FSM with registered grant outputs, rotation pointer and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            hcnt_r      <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        grant       <= win_onehot_s;
                        grant_id    <= win_idx_s;
                        grant_valid <= 1'b1;
                        hcnt_r      <= '0;
                        state_r     <= BUSY;
                    end
                end
                BUSY: begin
                    if (end_s) begin
                        ptr_r <= next_ptr_s;
                        if (win_found_s) begin
                            grant       <= win_onehot_s;
                            grant_id    <= win_idx_s;
                            grant_valid <= 1'b1;
                            hcnt_r      <= '0;
                        end else begin
                            grant       <= '0;
                            grant_id    <= '0;
                            grant_valid <= 1'b0;
                            hcnt_r      <= '0;
                            state_r     <= IDLE;
                        end
                    end else if (hcnt_r != {HCNT_W{1'b1}}) begin
                        hcnt_r <= hcnt_r + HCNT_W'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    grant       <= '0;
                    grant_id    <= '0;
                    grant_valid <= 1'b0;
                    hcnt_r      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: one unlimited-hold instance and one
// instance with a 3-cycle hold limit, each scenario checked against hand-derived values.
module tb_rr_grant_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req_a;
    logic       rel_a;
    logic [3:0] grant_a;
    logic       valid_a;
    logic [1:0] id_a;
    logic [3:0] req_b;
    logic       rel_b;
    logic [3:0] grant_b;
    logic       valid_b;
    logic [1:0] id_b;

    int tests_run;
    int tests_failed;

    rr_grant_scheduler #(.NUM_REQ(4), .MAX_HOLD(0)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .req           (req_a),
        .release_grant (rel_a),
        .grant         (grant_a),
        .grant_valid   (valid_a),
        .grant_id      (id_a)
    );

    rr_grant_scheduler #(.NUM_REQ(4), .MAX_HOLD(3)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .req           (req_b),
        .release_grant (rel_b),
        .grant         (grant_b),
        .grant_valid   (valid_b),
        .grant_id      (id_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = 4'b0000;
        rel_a = 1'b0;
        req_b = 4'b0000;
        rel_b = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req_a = 4'b1111;
        rel_a = 1'b0;
        req_b = 4'b0000;
        rel_b = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run++;
            if ({grant_a, valid_a, id_a} !== 7'b0000_0_00) begin
                tests_failed++;
                $display("FAIL reset_hold cyc%0d: grant=%b valid=%b id=%0d, required 0000/0/0", c, grant_a, valid_a, id_a);
            end
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b0001_1_00) begin
            tests_failed++;
            $display("FAIL reset_first_grant: grant=%b valid=%b id=%0d, required 0001/1/0", grant_a, valid_a, id_a);
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_ids [4];
        logic [3:0] exp_g;
        exp_ids = '{2'd1, 2'd2, 2'd3, 2'd0};
        req_a = 4'b1111;
        rel_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_g = 4'b0001 << exp_ids[k];
            tests_run++;
            if ({grant_a, valid_a, id_a} !== {exp_g, 1'b1, exp_ids[k]}) begin
                tests_failed++;
                $display("FAIL rotation step%0d: grant=%b valid=%b id=%0d, required %b/1/%0d", k, grant_a, valid_a, id_a, exp_g, exp_ids[k]);
            end
        end
        rel_a = 1'b0;
    endtask

    task automatic test_hold_unlimited();
        do_reset();
        req_a = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            tick();
            tests_run++;
            if ({grant_a, valid_a, id_a} !== 7'b0001_1_00) begin
                tests_failed++;
                $display("FAIL hold_unlimited cyc%0d: grant=%b valid=%b id=%0d, required 0001/1/0", c, grant_a, valid_a, id_a);
            end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        req_a = 4'b0100;
        tick();
        tests_run++;
        if ({grant_a, id_a} !== 6'b0100_10) begin
            tests_failed++;
            $display("FAIL wrap_setup: grant=%b id=%0d, required 0100/2", grant_a, id_a);
        end
        req_a = 4'b0101;
        rel_a = 1'b1;
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b0001_1_00) begin
            tests_failed++;
            $display("FAIL wrap_to_0: grant=%b valid=%b id=%0d, required 0001/1/0", grant_a, valid_a, id_a);
        end
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b0100_1_10) begin
            tests_failed++;
            $display("FAIL skip_to_2: grant=%b valid=%b id=%0d, required 0100/1/2", grant_a, valid_a, id_a);
        end
        req_a = 4'b0000;
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b0000_0_00) begin
            tests_failed++;
            $display("FAIL wrap_to_idle: grant=%b valid=%b id=%0d, required 0000/0/0", grant_a, valid_a, id_a);
        end
        rel_a = 1'b0;
    endtask

    task automatic test_implicit_release();
        do_reset();
        req_a = 4'b0010;
        tick();
        tests_run++;
        if ({grant_a, id_a} !== 6'b0010_01) begin
            tests_failed++;
            $display("FAIL implicit_setup: grant=%b id=%0d, required 0010/1", grant_a, id_a);
        end
        req_a = 4'b1000;
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b1000_1_11) begin
            tests_failed++;
            $display("FAIL implicit_handover: grant=%b valid=%b id=%0d, required 1000/1/3", grant_a, valid_a, id_a);
        end
        req_a = 4'b0000;
        rel_a = 1'b1;
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b0000_0_00) begin
            tests_failed++;
            $display("FAIL drop_and_release: grant=%b valid=%b id=%0d, required 0000/0/0", grant_a, valid_a, id_a);
        end
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b0000_0_00) begin
            tests_failed++;
            $display("FAIL idle_release_ignored: grant=%b valid=%b id=%0d, required 0000/0/0", grant_a, valid_a, id_a);
        end
        rel_a = 1'b0;
        req_a = 4'b0001;
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b0001_1_00) begin
            tests_failed++;
            $display("FAIL implicit_regrant: grant=%b valid=%b id=%0d, required 0001/1/0", grant_a, valid_a, id_a);
        end
        req_a = 4'b0000;
    endtask

    task automatic test_timeout();
        logic [1:0] exp_ids [7];
        logic [3:0] exp_g;
        exp_ids = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        do_reset();
        req_b = 4'b0011;
        for (int k = 0; k < 7; k++) begin
            tick();
            exp_g = 4'b0001 << exp_ids[k];
            tests_run++;
            if ({grant_b, valid_b, id_b} !== {exp_g, 1'b1, exp_ids[k]}) begin
                tests_failed++;
                $display("FAIL timeout cyc%0d: grant=%b valid=%b id=%0d, required %b/1/%0d", k, grant_b, valid_b, id_b, exp_g, exp_ids[k]);
            end
        end
        req_b = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_a = 4'b0100;
        tick();
        tests_run++;
        if ({grant_a, id_a} !== 6'b0100_10) begin
            tests_failed++;
            $display("FAIL midrst_setup: grant=%b id=%0d, required 0100/2", grant_a, id_a);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b0000_0_00) begin
            tests_failed++;
            $display("FAIL midrst_clear: grant=%b valid=%b id=%0d, required 0000/0/0", grant_a, valid_a, id_a);
        end
        rst   = 1'b0;
        req_a = 4'b0110;
        tick();
        tests_run++;
        if ({grant_a, valid_a, id_a} !== 7'b0010_1_01) begin
            tests_failed++;
            $display("FAIL midrst_first: grant=%b valid=%b id=%0d, required 0010/1/1", grant_a, valid_a, id_a);
        end
        req_a = 4'b0000;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        req_a = 4'b0000;
        rel_a = 1'b0;
        req_b = 4'b0000;
        rel_b = 1'b0;
        test_reset();
        test_rotation();
        test_hold_unlimited();
        test_wrap_skip();
        test_implicit_release();
        test_timeout();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
